// File: rtl/ripple_carry_adder_16bit.sv
// Purpose: 16-bit ripple-carry adder with registered sum, carry-out, signed overflow and zero flags.
// Latency: 1 clk from operand sampling edge to registered result.
// Backpressure: none; a new operation is accepted on every rising clk.
module ripple_carry_adder_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   // carry_w[i] enters bit i; carry_w[WIDTH] leaves the MSB
   logic [WIDTH:0]   carry_w;
   logic [WIDTH-1:0] sum_d;
   logic             c_out_d;
   logic             ovf_d;
   logic             zero_d;

   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             zero_q;

   assign carry_w[0] = c_in;

   // One full adder per bit; each stage waits on the carry of the stage below
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic p_w;
      assign p_w          = in1[i] ^ in2[i];
      assign sum_d[i]     = p_w ^ carry_w[i];
      assign carry_w[i+1] = (in1[i] & in2[i]) | (carry_w[i] & p_w);
   end

   // Flags derived from the chain: overflow when carry into and out of the MSB disagree
   always_comb begin
      c_out_d = carry_w[WIDTH];
      ovf_d   = carry_w[WIDTH-1] ^ carry_w[WIDTH];
      zero_d  = (sum_d == '0);
   end

   // Result register; reset wins over the computation and discards that edge's operands
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;
   assign zero  = zero_q;

endmodule

// File: tb/tb_ripple_carry_adder_16bit.sv
// Purpose: scoreboard bench for ripple_carry_adder_16bit using directed and random vectors.
// Latency: expects each result one rising edge after its operands are driven.
// Backpressure: none; one vector per cycle, checked by an independent monitor.
module tb_ripple_carry_adder_16bit;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        c_in;
   logic [15:0] sum;
   logic        c_out;
   logic        ovf;
   logic        zero;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   ripple_carry_adder_16bit #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .in1   (in1),
      .in2   (in2),
      .c_in  (c_in),
      .sum   (sum),
      .c_out (c_out),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   // Drive one vector on the falling edge and queue what the next rising edge must produce
   task automatic apply(input bit r, input logic [15:0] a, input logic [15:0] b, input bit c,
                        input logic [15:0] es, input bit eco, input bit eov, input bit ez,
                        input string nm);
      exp_t e;
      @(negedge clk);
      rst  = r;
      in1  = a;
      in2  = b;
      c_in = c;
      e = {es, eco, eov, ez};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: after every rising edge, retire one expected result if one is pending
   always @(posedge clk) begin
      exp_t  e;
      exp_t  got;
      string nm;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {sum, c_out, ovf, zero};
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL %s: got sum=%h c_out=%b ovf=%b zero=%b, want sum=%h c_out=%b ovf=%b zero=%b",
                     nm, got.s, got.co, got.ov, got.z, e.s, e.co, e.ov, e.z);
         end
      end
   end

   initial begin
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [16:0] r;
      logic        ov;
      int          wait_cyc;

      rst  = 1'b1;
      in1  = '0;
      in2  = '0;
      c_in = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state and reset-discards-operands, then immediate resume
      apply(1, 16'h1234, 16'h1111, 0, 16'h0000, 0, 0, 1, "rst_discard");
      apply(0, 16'h1234, 16'h1111, 0, 16'h2345, 0, 0, 0, "first_after_rst");
      apply(0, 16'h6A6A, 16'h2E66, 0, 16'h98D0, 0, 1, 0, "6a6a_2e66_c0");
      apply(0, 16'h6A6A, 16'h2E66, 1, 16'h98D1, 0, 1, 0, "6a6a_2e66_c1");
      apply(0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, "full_ripple");
      apply(0, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1, 1, "neg_ovf_zero");
      apply(0, 16'h7FFF, 16'h0000, 1, 16'h8000, 0, 1, 0, "pos_ovf_cin");
      apply(0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0, 1, "wrap_ffff_cin");
      apply(0, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0, "ffff_ffff_cin");
      apply(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, "all_zero");
      apply(0, 16'h5555, 16'hAAAA, 0, 16'hFFFF, 0, 0, 0, "alt_bits_c0");
      apply(0, 16'h5555, 16'hAAAA, 1, 16'h0000, 1, 0, 1, "alt_bits_c1");
      apply(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0, "pos_ovf");
      apply(0, 16'h8000, 16'hFFFF, 0, 16'h7FFF, 1, 1, 0, "neg_ovf");
      // Reset between two operations clears only that edge
      apply(1, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 0, 0, 1, "mid_rst");
      apply(0, 16'h0001, 16'h0001, 0, 16'h0002, 0, 0, 0, "resume_after_rst");
      apply(0, 16'h00FF, 16'h0001, 0, 16'h0100, 0, 0, 0, "byte_carry");

      // Back-to-back random vectors against a plain 17-bit arithmetic reference
      for (int i = 0; i < 300; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         c  = 1'($urandom_range(0, 1));
         r  = {1'b0, a} + {1'b0, b} + {16'h0000, c};
         ov = (a[15] == b[15]) && (r[15] != a[15]);
         apply(0, a, b, c, r[15:0], r[16], ov, (r[15:0] == 16'h0000), "random");
      end

      // Let the monitor drain the queue, bounded
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
